// File: rtl/serial_share_sched.sv
// Round-robin time-sharing of one digit-serial deserializer among NREQ producers; frame_cnt built only with SCHED_FRAME_CNT_EN.
// Latency: gnt 1 cycle after req in IDLE, digit k on ser_data at gnt+k+1, frame_vld at gnt+CYCS+1.
// Backpressure: none; a granted frame always runs CYCS beats and waiting producers hold req until granted.
module serial_share_sched #(
    parameter int BW      = 16,
    parameter int CYCS    = 4,
    parameter int VEC_LEN = 27,
    parameter int NREQ    = 4,
    localparam int DW     = BW / CYCS,
    localparam int IDW    = $clog2(NREQ)
) (
    input  logic                                  clock,
    input  logic                                  reset_n,
    input  logic [NREQ-1:0]                       req,
    input  logic [NREQ-1:0][VEC_LEN-1:0][DW-1:0]  digit_in,
    output logic [NREQ-1:0]                       gnt,
    output logic                                  ser_vld,
    output logic [VEC_LEN-1:0][DW-1:0]            ser_data,
    output logic                                  frame_vld,
    output logic [IDW-1:0]                        frame_id,
    output logic [31:0]                           frame_cnt
);
    localparam int BCW = $clog2(CYCS);
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(CYCS - 1);

    typedef enum logic [1:0] {FLUSH, IDLE, XFER} state_t;

    state_t          state;
    logic [BCW-1:0]  beat;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  owner;
    logic [IDW-1:0]  nxt_ptr;
    logic [IDW-1:0]  arb_base;
    logic [IDW-1:0]  arb_idx;
    logic [IDW-1:0]  cand;
    logic            arb_any;
    logic [NREQ-1:0] arb_oh;
    logic            frame_pend;
    logic [IDW-1:0]  pend_id;
    int              j;

    assign nxt_ptr  = (owner == IDW'(NREQ - 1)) ? '0 : owner + 1'b1;
    // At the end of a frame the search already starts past the finishing owner.
    assign arb_base = (state == XFER) ? nxt_ptr : ptr;
    assign arb_oh   = {{(NREQ-1){1'b0}}, 1'b1} << arb_idx;

    // Scan from farthest to nearest so the first requester at/after arb_base wins.
    always_comb begin
        arb_any = 1'b0;
        arb_idx = '0;
        cand    = '0;
        j       = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            j = int'(arb_base) + i;
            if (j >= NREQ) j = j - NREQ;
            cand = IDW'(j);
            if (req[cand]) begin
                arb_any = 1'b1;
                arb_idx = cand;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= FLUSH;
            beat       <= '0;
            ptr        <= '0;
            owner      <= '0;
            gnt        <= '0;
            ser_vld    <= 1'b0;
            ser_data   <= '0;
            frame_vld  <= 1'b0;
            frame_id   <= '0;
            frame_pend <= 1'b0;
            pend_id    <= '0;
        end else begin
            frame_vld  <= frame_pend;
            if (frame_pend) frame_id <= pend_id;
            frame_pend <= 1'b0;
            ser_vld    <= 1'b0;
            case (state)
                FLUSH: begin
                    if (beat == LAST_BEAT) begin
                        beat  <= '0;
                        state <= IDLE;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                IDLE: begin
                    if (arb_any) begin
                        gnt   <= arb_oh;
                        owner <= arb_idx;
                        beat  <= '0;
                        state <= XFER;
                    end
                end
                XFER: begin
                    ser_vld  <= 1'b1;
                    ser_data <= digit_in[owner];
                    if (beat == LAST_BEAT) begin
                        frame_pend <= 1'b1;
                        pend_id    <= owner;
                        ptr        <= nxt_ptr;
                        beat       <= '0;
                        if (arb_any) begin
                            gnt   <= arb_oh;
                            owner <= arb_idx;
                        end else begin
                            gnt   <= '0;
                            state <= IDLE;
                        end
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                default: begin
                    state <= FLUSH;
                    beat  <= '0;
                    gnt   <= '0;
                end
            endcase
        end
    end

`ifdef SCHED_FRAME_CNT_EN
    logic [31:0] cnt_q;

    // Counts on the edge that raises frame_vld so the count tracks the pulse.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (frame_pend) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign frame_cnt = cnt_q;
`else
    assign frame_cnt = '0;
`endif

endmodule
